// File: rtl/div_186by93_seq_if.sv
// Handshake and result bundle for the 2N-by-N sequential divider.
// The requester uses the master modport and the divider uses the slave modport.
interface div_186by93_seq_if #(
  parameter int N = 93
);
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/div_186by93_seq.sv
// Restoring divider: a 2N-bit dividend divided by an N-bit divisor.
// It produces one quotient bit per clock and raises error flags for divide-by-zero or quotient overflow.
module div_186by93_seq #(
  parameter int N = 93
) (
  input  logic               clk,
  input  logic               rst,
  div_186by93_seq_if.slave   bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [N:0]    pr_q, pr_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  divisor_q, divisor_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [N:0]    trial;
  logic [N:0]    diff;
  logic          fits;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pr_q        <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pr_q        <= pr_d;
      q_q         <= q_d;
      divisor_q   <= divisor_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  // The partial remainder stays below the divisor, so the shifted trial value always fits in N+1 bits.
  always_comb begin
    trial = {pr_q[N-1:0], q_q[N-1]};
    diff  = trial - {1'b0, divisor_q};
    fits  = (trial >= {1'b0, divisor_q});
  end

  always_comb begin
    state_d     = state_q;
    pr_d        = pr_q;
    q_d         = q_q;
    divisor_d   = divisor_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
            quotient_d  = '1;
            remainder_d = '0;
            done_d      = 1'b1;
          end else if (bus.dividend[2*N-1:N] >= bus.divisor) begin
            dbz_d       = 1'b0;
            ovf_d       = 1'b1;
            quotient_d  = '1;
            remainder_d = '0;
            done_d      = 1'b1;
          end else begin
            dbz_d     = 1'b0;
            ovf_d     = 1'b0;
            pr_d      = {1'b0, bus.dividend[2*N-1:N]};
            q_d       = bus.dividend[N-1:0];
            divisor_d = bus.divisor;
            cnt_d     = CW'(N);
            busy_d    = 1'b1;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        pr_d  = fits ? diff : trial;
        q_d   = {q_q[N-2:0], fits};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          quotient_d  = q_d;
          remainder_d = pr_d[N-1:0];
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
endmodule
